tour_cmd_seq: RTL
=================

Name: tour_cmd_seq

Overview:
Sequences the solved Knight's tour into motion commands for the command processor. After the solver finishes, it fetches each one-hot move from the move memory and issues two commands per move: a vertical leg, then a horizontal leg with fanfare. Each leg waits for the command processor's completion before the next is issued. When no tour is running, it passes UART commands straight through, so the command processor has a single command source.

Parameters:
NUM_MOVES, 24, number of tour moves to replay (5x5 board); index runs 0..NUM_MOVES-1
IDX_W, 5, width of mv_indx

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_tour  in  1  one-cycle pulse from solver: solution ready, begin replay
move  in  8  one-hot move read from solver memory; valid the cycle after mv_indx changes
mv_indx  out  IDX_W  move-memory read index
cmd_UART  in  16  command from UART wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy_UART  out  1  pulse: UART command consumed
cmd  out  16  command to command processor {opcode[15:12], heading[11:4], squares[3:0]}
cmd_rdy  out  1  cmd valid; held until clr_cmd_rdy
clr_cmd_rdy  in  1  command processor accepted cmd
send_resp  in  1  command processor finished executing cmd
resp  out  8  response byte to UART: 8'h5A while tour active, 8'hA5 otherwise
tour_active  out  1  high from start_tour until final leg completes or abort
tour_err  out  1  one-cycle pulse on invalid (non-one-hot) move

Behaviour:
- Reset values: mv_indx=0, cmd_rdy=0, clr_cmd_rdy_UART=0, tour_active=0, tour_err=0, resp=8'hA5, and the FSM goes to IDLE.
- Move decode (bit: dx,dy):
  - 0:(+1,+2), 1:(-1,+2), 2:(-2,+1), 3:(-2,-1)
  - 4:(-1,-2), 5:(+1,-2), 6:(+2,-1), 7:(+2,+1)
- Leg command encoding:
  - Vertical leg: opcode 4'h2; heading 8'h00 if dy>0, 8'h7F if dy<0; squares |dy|.
  - Horizontal leg: opcode 4'h3 (move with fanfare); heading 8'hBF if dx>0, 8'h3F if dx<0; squares |dx|.
- IDLE (pass-through):
  - cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5.
  - start_tour goes to FETCH: mv_indx=0, tour_active=1. Pass-through cmd_rdy drops the same cycle.
- FETCH: wait one cycle for move memory, then go to DECODE.
- DECODE: register move.
  - If not one-hot: pulse tour_err, clear tour_active, return to IDLE.
  - Otherwise load the vertical cmd, assert cmd_rdy, go to VERT.
- VERT: hold cmd_rdy until clr_cmd_rdy, drop it the next cycle, go to WAIT_V.
- WAIT_V: on send_resp, load the horizontal cmd, assert cmd_rdy, go to HORZ.
- HORZ / WAIT_H: mirror VERT / WAIT_V. On send_resp in WAIT_H:
  - If mv_indx==NUM_MOVES-1: clear tour_active, go to IDLE.
  - Else: mv_indx+1, go to FETCH.
- While tour_active:
  - UART commands are not accepted; clr_cmd_rdy_UART stays 0 and cmd_rdy_UART stays pending untouched.
  - resp=8'h5A.
- Simultaneous events:
  - start_tour in the same cycle as cmd_rdy_UART: the tour wins and the UART command stays pending.
  - start_tour while tour_active is ignored.
  - send_resp outside the WAIT states is ignored.
- Reset mid-tour: everything returns to the reset values within one cycle; cmd_rdy drops immediately.
- Latency: start_tour to first cmd_rdy is 3 cycles. Leg send_resp to next leg's cmd_rdy is 1 cycle within a move, 3 cycles between moves.

Decomposition:
- Shared package holds:
  - Opcodes: OP_MOVE=4'h2, OP_MOVE_FF=4'h3.
  - Headings: HDG_N=8'h00, HDG_W=8'h3F, HDG_S=8'h7F, HDG_E=8'hBF.
  - Response bytes: RESP_TOUR=8'h5A, RESP_POS=8'hA5.
  - The state enum.
- One sub-module: knight_move_decode (combinational: one-hot move to vertical/horizontal cmd words plus valid flag).

Test Plan:
- Pass-through: idle, cmd_UART=16'h2001 with cmd_rdy_UART -> cmd=16'h2001, cmd_rdy=1, clr_cmd_rdy_UART follows clr_cmd_rdy, resp=8'hA5.
- Single move: start_tour, move=8'h04 (from (2,0) to (0,1)) -> cmd 16'h2001, then after send_resp cmd 16'h33F2; resp=8'h5A for both legs.
- Move bit 5 -> legs 16'h27F2 then 16'h3BF1; move bit 7 -> 16'h2001 then 16'h3BF2.
- Full replay with NUM_MOVES=3: 6 legs issued in order; mv_indx 0,1,2; tour_active falls after the 6th send_resp; a following UART command passes through.
- Errors and arbitration:
  - move=8'h06 -> tour_err pulse, no cmd_rdy, back to IDLE.
  - start_tour coincident with cmd_rdy_UART -> tour leg issued first, UART cmd held pending.
- rst asserted while waiting in WAIT_V -> next cycle cmd_rdy=0, tour_active=0, mv_indx=0; a new start_tour restarts from index 0.

Source files
------------

// File: rtl/tour_cmd_seq_pkg.sv
// Shared constants and FSM state encoding for the knight's tour command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tour_cmd_seq_pkg;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_MOVE_FF = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_TOUR = 8'h5A;
    localparam logic [7:0] RESP_POS  = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_VERT,
        S_WAIT_V,
        S_HORZ,
        S_WAIT_H
    } state_t;

endpackage

// File: rtl/tour_cmd_seq_decode.sv
// Decodes a one-hot knight move into a vertical leg and a horizontal (fanfare) leg.
// Latency: combinational.
// Backpressure: none; valid is low for any input that is not exactly one-hot.
module knight_move_decode
    import tour_cmd_seq_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd,
    output logic        valid
);

    logic       dx_neg;
    logic       dy_neg;
    logic [1:0] dx_mag;
    logic [1:0] dy_mag;

    // Map each move bit to the signed (dx,dy) displacement as sign + magnitude.
    always_comb begin
        dx_neg = 1'b0;
        dy_neg = 1'b0;
        dx_mag = 2'd0;
        dy_mag = 2'd0;
        valid  = 1'b1;
        case (move)
            8'h01: begin                dx_mag = 2'd1;                dy_mag = 2'd2; end
            8'h02: begin dx_neg = 1'b1; dx_mag = 2'd1;                dy_mag = 2'd2; end
            8'h04: begin dx_neg = 1'b1; dx_mag = 2'd2;                dy_mag = 2'd1; end
            8'h08: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
            8'h10: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
            8'h20: begin                dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
            8'h40: begin                dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
            8'h80: begin                dx_mag = 2'd2;                dy_mag = 2'd1; end
            default: valid = 1'b0;
        endcase
    end

    assign vert_cmd = {OP_MOVE,    (dy_neg ? HDG_S : HDG_N), 2'b00, dy_mag};
    assign horz_cmd = {OP_MOVE_FF, (dx_neg ? HDG_W : HDG_E), 2'b00, dx_mag};

endmodule

// File: rtl/tour_cmd_seq.sv
// Replays the solved knight's tour as vertical/horizontal leg commands; UART pass-through when idle.
// Latency: start_tour->first cmd_rdy 3 cycles; send_resp->next leg 1 cycle (same move) or 3 (next move).
// Backpressure: cmd_rdy held until clr_cmd_rdy; next leg waits for send_resp; UART cmd left pending while touring.
module tour_cmd_seq
    import tour_cmd_seq_pkg::*;
#(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             clr_cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_active,
    output logic             tour_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
    logic [7:0]       move_q, move_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             tour_err_q, tour_err_d;

    logic [7:0]       dec_move;
    logic [15:0]      vert_cmd;
    logic [15:0]      horz_cmd;
    logic             dec_vld;
    logic             pass_thru;

    // In DECODE the live memory word is decoded; afterwards the captured copy feeds the horizontal leg.
    assign dec_move = (state_q == S_DECODE) ? move : move_q;

    knight_move_decode u_decode (
        .move     (dec_move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd),
        .valid    (dec_vld)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mv_indx_q  <= '0;
            move_q     <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            tour_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mv_indx_q  <= mv_indx_d;
            move_q     <= move_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            tour_err_q <= tour_err_d;
        end
    end

    // Next-state logic: fetch, decode, then issue two handshaked legs per move.
    always_comb begin
        state_d    = state_q;
        mv_indx_d  = mv_indx_q;
        move_d     = move_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        tour_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_tour) begin
                    mv_indx_d = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                move_d = move;
                if (!dec_vld) begin
                    tour_err_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cmd_d     = vert_cmd;
                    cmd_rdy_d = 1'b1;
                    state_d   = S_VERT;
                end
            end
            S_VERT: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = S_WAIT_V;
                end
            end
            S_WAIT_V: begin
                if (send_resp) begin
                    cmd_d     = horz_cmd;
                    cmd_rdy_d = 1'b1;
                    state_d   = S_HORZ;
                end
            end
            S_HORZ: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = S_WAIT_H;
                end
            end
            S_WAIT_H: begin
                if (send_resp) begin
                    if (mv_indx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + IDX_W'(1);
                        state_d   = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Idle pass-through is cut off the moment a tour starts or reset is applied.
    assign pass_thru        = (state_q == S_IDLE) && !start_tour && !rst;
    assign cmd              = pass_thru ? cmd_UART : cmd_q;
    assign cmd_rdy          = pass_thru ? cmd_rdy_UART : (cmd_rdy_q && !rst);
    assign clr_cmd_rdy_UART = pass_thru && clr_cmd_rdy;
    assign tour_active      = (state_q != S_IDLE);
    assign resp             = tour_active ? RESP_TOUR : RESP_POS;
    assign tour_err         = tour_err_q;
    assign mv_indx          = mv_indx_q;

endmodule
